// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the serial pattern-detect stream controller:
// FSM state encoding and the default target pattern.
package seq_detect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_detect_ctrl_match_core.sv
// Programmable 4-bit Mealy matcher: 3-bit history plus saturating fill count,
// optional non-overlapping mode, synchronous clear and a registered match pulse.
module seq_match_core (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic [3:0] pattern,
    input  logic       overlap,
    output logic       hit,
    output logic       match
);

    logic [2:0] hist;
    logic [1:0] fill;

    // hit is the same-cycle decision; the controller's counter consumes it so
    // that the count and the registered pulse become visible together.
    always_comb begin
        hit = bit_valid && (fill == 2'd3) && ({hist, bit_in} == pattern);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= hit;
            if (clear) begin
                hist <= '0;
                fill <= '0;
            end else if (bit_valid) begin
                if (hit && !overlap) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= {hist[1:0], bit_in};
                    if (fill != 2'd3) fill <= fill + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-to-bit stream controller: accepts words over valid/ready, feeds them
// MSB-first into the matcher, counts matches per job and flags job completion.
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [3:0]        cfg_pattern,
    input  logic              cfg_overlap,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              busy,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              count_sat,
    output logic              done
);

    localparam int IDX_W = $clog2(DATA_W);

    state_t             state, next_state;
    logic [DATA_W-1:0]  shreg;
    logic [IDX_W-1:0]   bit_idx;
    logic               last_q;
    logic [3:0]         pattern_q;
    logic               overlap_q;
    logic               in_ready_d, busy_d, done_d;
    logic               job_start, accept, shifting, hit;

    assign job_start = (state == ST_IDLE) && start;
    assign accept    = (state == ST_LOAD) && in_valid && in_ready;
    assign shifting  = (state == ST_SHIFT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= in_ready_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // NOTE: defaulting next_state before the case keeps this block free of
    // inferred latches on any path that does not assign it.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_LOAD;
            ST_LOAD:  if (in_valid && in_ready) next_state = ST_SHIFT;
            ST_SHIFT: if (bit_idx == '0) next_state = last_q ? ST_DONE : ST_LOAD;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered, so they line up
    // with the state they describe without any combinational output path.
    always_comb begin
        in_ready_d = (next_state == ST_LOAD);
        busy_d     = (next_state != ST_IDLE);
        done_d     = (next_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg       <= '0;
            bit_idx     <= '0;
            last_q      <= 1'b0;
            pattern_q   <= DEFAULT_PATTERN;
            overlap_q   <= 1'b1;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            if (job_start) begin
                pattern_q   <= cfg_pattern;
                overlap_q   <= cfg_overlap;
                match_count <= '0;
                count_sat   <= 1'b0;
            end
            if (accept) begin
                shreg   <= in_data;
                last_q  <= in_last;
                bit_idx <= IDX_W'(DATA_W - 1);
            end else if (shifting) begin
                shreg   <= shreg << 1;
                bit_idx <= bit_idx - IDX_W'(1);
            end
            // hit only occurs in SHIFT, so it never collides with job_start.
            if (hit) begin
                if (&match_count) count_sat <= 1'b1;
                else              match_count <= match_count + CNT_W'(1);
            end
        end
    end

    seq_match_core u_match (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (job_start),
        .bit_valid (shifting),
        .bit_in    (shreg[DATA_W-1]),
        .pattern   (pattern_q),
        .overlap   (overlap_q),
        .hit       (hit),
        .match     (match_pulse)
    );

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: a default instance plus a CNT_W=2
// instance driven in lockstep to exercise counter saturation.
module tb_seq_detect_ctrl;
    import seq_detect_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] cfg_pattern = 4'b1011;
    logic       cfg_overlap = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;

    logic        in_ready, busy, match_pulse, count_sat, done;
    logic [15:0] match_count;
    logic        s_in_ready, s_busy, s_match_pulse, s_count_sat, s_done;
    logic [1:0]  s_match_count;

    int checks = 0;
    int errors = 0;

    // Results of the most recent run_job
    int          pulses[$];
    int          readys[$];
    int          done_at;
    int          accepts;
    logic [15:0] cnt_after_start, cnt_at_done;
    logic        sat_at_done;
    logic [1:0]  s_cnt_after_start, s_cnt_at_done;
    logic        s_sat_after_start, s_sat_at_done;
    logic        done_next, busy_next;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .busy(busy),
        .match_pulse(match_pulse), .match_count(match_count),
        .count_sat(count_sat), .done(done)
    );

    seq_detect_ctrl #(.DATA_W(8), .CNT_W(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(s_in_ready), .busy(s_busy),
        .match_pulse(s_match_pulse), .match_count(s_match_count),
        .count_sat(s_count_sat), .done(s_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one job; cycle numbers are counted in edges after the edge that sampled start.
    task automatic run_job(input logic [3:0] pat, input logic ovl,
                           input logic [7:0] w0, input logic [7:0] w1, input int nwords);
        int   rel;
        int   widx;
        logic rdy;
        bit   lock_ok;
        pulses.delete();
        readys.delete();
        done_at = -1;
        accepts = 0;
        lock_ok = 1'b1;
        cfg_pattern = pat;
        cfg_overlap = ovl;
        start = 1'b1;
        step();
        start = 1'b0;
        rel = 0;
        cnt_after_start   = match_count;
        s_cnt_after_start = s_match_count;
        s_sat_after_start = s_count_sat;
        in_valid = 1'b1;
        in_data  = w0;
        in_last  = (nwords == 1);
        widx = 0;
        if (in_ready) readys.push_back(0);
        while (rel < 100 && done_at < 0) begin
            rdy = in_ready;
            step();
            rel++;
            if (rdy && in_valid) begin
                accepts++;
                widx++;
                if (widx < nwords) begin
                    in_data = w1;
                    in_last = 1'b1;
                end
            end
            if (in_ready) readys.push_back(rel);
            if (match_pulse) pulses.push_back(rel);
            if ({s_in_ready, s_busy, s_done, s_match_pulse} !== {in_ready, busy, done, match_pulse})
                lock_ok = 1'b0;
            if (done) begin
                done_at       = rel;
                cnt_at_done   = match_count;
                sat_at_done   = count_sat;
                s_cnt_at_done = s_match_count;
                s_sat_at_done = s_count_sat;
            end
        end
        step();
        done_next = done;
        busy_next = busy;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (!lock_ok) begin
            errors++;
            $display("FAIL lockstep: the two instances disagreed on handshake/pulse outputs");
        end
        checks++;
        if (done_at < 0) begin
            errors++;
            $display("FAIL job_timeout: done not seen within 100 cycles");
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        checks++;
        if ({in_ready, busy, done, match_pulse, count_sat} !== 5'b0 || match_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b pulse=%b sat=%b cnt=%0d, want all 0",
                     in_ready, busy, done, match_pulse, count_sat, match_count);
        end
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b rdy=%b, want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_overlap();
        run_job(4'b1011, 1'b1, 8'b1011_0110, 8'h00, 1);
        checks++;
        if (pulses.size() != 2 || pulses[0] != 5 || pulses[1] != 8) begin
            errors++;
            $display("FAIL overlap_pulses: got n=%0d first=%0d second=%0d, want n=2 at 5,8",
                     pulses.size(), pulses[0], pulses[1]);
        end
        checks++;
        if (done_at != 9 || cnt_at_done !== 16'd2) begin
            errors++;
            $display("FAIL overlap_done: got done_at=%0d cnt=%0d, want 9 and 2", done_at, cnt_at_done);
        end
        checks++;
        if (done_next !== 1'b0 || busy_next !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: got done=%b busy=%b after DONE, want 0 0", done_next, busy_next);
        end
    endtask

    task automatic test_non_overlap();
        run_job(4'b1011, 1'b0, 8'b1011_0110, 8'h00, 1);
        checks++;
        if (cnt_after_start !== 16'd0) begin
            errors++;
            $display("FAIL start_clears_count: got %0d, want 0", cnt_after_start);
        end
        checks++;
        if (pulses.size() != 1 || pulses[0] != 5 || cnt_at_done !== 16'd1) begin
            errors++;
            $display("FAIL non_overlap: got n=%0d first=%0d cnt=%0d, want n=1 at 5 cnt=1",
                     pulses.size(), pulses[0], cnt_at_done);
        end
    endtask

    task automatic test_cross_boundary();
        run_job(4'b1011, 1'b1, 8'b0000_0101, 8'b1000_0000, 2);
        checks++;
        if (pulses.size() != 1 || pulses[0] != 11) begin
            errors++;
            $display("FAIL cross_pulse: got n=%0d first=%0d, want n=1 at 11", pulses.size(), pulses[0]);
        end
        checks++;
        if (cnt_at_done !== 16'd1 || done_at != 18) begin
            errors++;
            $display("FAIL cross_done: got cnt=%0d done_at=%0d, want 1 and 18", cnt_at_done, done_at);
        end
    endtask

    task automatic test_saturation();
        run_job(4'b1111, 1'b1, 8'hFF, 8'h00, 1);
        checks++;
        if (pulses.size() != 5 || pulses[0] != 5 || pulses[4] != 9) begin
            errors++;
            $display("FAIL sat_pulses: got n=%0d first=%0d last=%0d, want n=5 at 5..9",
                     pulses.size(), pulses[0], pulses[4]);
        end
        checks++;
        if (s_cnt_at_done !== 2'd3 || s_sat_at_done !== 1'b1) begin
            errors++;
            $display("FAIL sat_count: got cnt=%0d sat=%b, want 3 and 1", s_cnt_at_done, s_sat_at_done);
        end
        checks++;
        if (cnt_at_done !== 16'd5 || sat_at_done !== 1'b0) begin
            errors++;
            $display("FAIL wide_count: got cnt=%0d sat=%b, want 5 and 0", cnt_at_done, sat_at_done);
        end
        checks++;
        if (s_count_sat !== 1'b1 || s_match_count !== 2'd3) begin
            errors++;
            $display("FAIL sat_hold_idle: got cnt=%0d sat=%b, want 3 and 1", s_match_count, s_count_sat);
        end
        run_job(4'b1111, 1'b1, 8'h00, 8'h00, 1);
        checks++;
        if (s_cnt_after_start !== 2'd0 || s_sat_after_start !== 1'b0) begin
            errors++;
            $display("FAIL sat_cleared: got cnt=%0d sat=%b after start, want 0 0",
                     s_cnt_after_start, s_sat_after_start);
        end
        checks++;
        if (pulses.size() != 0 || s_cnt_at_done !== 2'd0 || s_sat_at_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_word: got n=%0d cnt=%0d sat=%b, want 0 0 0",
                     pulses.size(), s_cnt_at_done, s_sat_at_done);
        end
    endtask

    task automatic test_handshake();
        run_job(4'b1011, 1'b1, 8'hB0, 8'h0B, 2);
        checks++;
        if (accepts != 2 || readys.size() != 2 || readys[0] != 0 || readys[1] != 9) begin
            errors++;
            $display("FAIL handshake_ready: got accepts=%0d ready_n=%0d at %0d,%0d, want 2, 2 at 0,9",
                     accepts, readys.size(), readys[0], readys[1]);
        end
        checks++;
        if (done_at != 18) begin
            errors++;
            $display("FAIL handshake_latency: got done_at=%0d, want 18", done_at);
        end
        checks++;
        if (cnt_at_done !== 16'd2 || pulses.size() != 2 || pulses[0] != 5 || pulses[1] != 18) begin
            errors++;
            $display("FAIL handshake_matches: got cnt=%0d n=%0d at %0d,%0d, want 2, 2 at 5,18",
                     cnt_at_done, pulses.size(), pulses[0], pulses[1]);
        end
    endtask

    task automatic test_reset_mid_shift();
        bit stray;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (match_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_idle_count: got %0d, want 0", match_count);
        end
        step();
        reset_n = 1'b1;
        cfg_pattern = 4'b1011;
        cfg_overlap = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hB6;
        in_last  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b1 || dut.state !== ST_SHIFT) begin
            errors++;
            $display("FAIL pre_reset_shift: got busy=%b state=%0d, want 1 and SHIFT", busy, dut.state);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, done, match_pulse, count_sat} !== 5'b0 || match_count !== 16'd0 ||
            dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid_shift: got rdy=%b busy=%b done=%b pulse=%b sat=%b cnt=%0d state=%0d, want all 0 IDLE",
                     in_ready, busy, done, match_pulse, count_sat, match_count, dut.state);
        end
        step();
        reset_n = 1'b1;
        in_valid = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (in_ready !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL no_accept_without_start: got in_ready/busy high after reset, want 0");
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_cross_boundary();
        test_saturation();
        test_handshake();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Stream controller for the team's serial 1011-class Mealy pattern detection. It accepts parallel words over a valid/ready handshake and serialises them MSB-first into an internal programmable 4-bit matcher. Detector history is carried across word boundaries. It counts matches per job and signals job completion. It sits between a word-oriented producer and status/interrupt logic.

Parameters:
DATA_W, 8, width of input word (>=4)
CNT_W, 16, width of match counter

Ports:
clk  input  1  single system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle job start; sampled only in IDLE
cfg_pattern  input  4  target pattern, bit3 = first bit in time; latched on accepted start
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping; latched on accepted start
in_valid  input  1  word valid
in_data  input  DATA_W  word, serialised MSB first
in_last  input  1  marks final word of job; qualified by in_valid
in_ready  output  1  controller can accept a word
busy  output  1  job in progress (not IDLE)
match_pulse  output  1  one-cycle pulse per detected match
match_count  output  CNT_W  matches in current/last job
count_sat  output  1  sticky: counter saturated this job
done  output  1  one-cycle pulse at end of job

Behaviour:
- Reset, asynchronous on reset_n low: FSM=IDLE, in_ready=0, busy=0, done=0, match_pulse=0, match_count=0, count_sat=0, history cleared. Applies mid-job too: the partial job is discarded and the next job needs a new start.
- All outputs are registered.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: start=1 latches cfg, clears match_count, count_sat, history and fill count, then goes to LOAD. start while busy is ignored.
- LOAD: in_ready=1. On in_valid&in_ready: capture in_data into shift register, latch in_last, set bit index=DATA_W-1, go to SHIFT. Producer must hold in_data/in_last stable while in_valid&!in_ready.
- SHIFT: in_ready=0. Each cycle consumes one bit b=shreg MSB, then shifts left.
  - After DATA_W bits, go to DONE if last was latched, else LOAD.
  - Throughput is DATA_W+1 cycles per word; the LOAD cycle is a bubble.
- Matcher state: 3-bit history h of prior bits plus fill count f (0..3, saturating).
  - A match occurs on bit b when f==3 and {h,b}==cfg_pattern.
  - On match with cfg_overlap=1: history continues normally.
  - On match with cfg_overlap=0: h and f are cleared after the bit.
  - Otherwise h<={h[1:0],b} and f increments to saturation.
  - History persists across words within a job and is cleared only by start or reset.
- Latency: a match on the bit consumed in cycle t gives match_pulse=1 in t+1, with match_count updated in t+1.
- Counter: increments by 1 per match and saturates at all-ones. An increment attempted at all-ones sets count_sat, which stays set until the next start.
- DONE: lasts one cycle. done=1 and busy=1, and the final match_count is valid (the last bit's match is already reflected). Then go to IDLE.
- match_count holds its value in IDLE until the next start.
- in_valid outside LOAD is ignored (not accepted). start during DONE is ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE/LOAD/SHIFT/DONE, 2-bit).
  - Default pattern constant 4'b1011.
- One natural sub-module: seq_match_core, the programmable 4-bit matcher (h, f, overlap mode, clear input, registered match output).
- The controller keeps the FSM, shift register, bit index and counter.

Test Plan:
- Single word, overlap: pattern 1011, overlap=1, word 8'b1011_0110 with last -> match_pulse after stream bits 3 and 6, match_count=2, done one cycle later.
- Same word, non-overlap: overlap=0 -> a single match (stream bit 3), match_count=1.
- Cross-boundary match: pattern 1011, words 8'b0000_0101 then 8'b1000_0000 (last) -> exactly one match, pulse in the cycle after the first bit of word 2 is consumed; match_count=1.
- Saturation: CNT_W=2, pattern 1111, overlap=1, word 8'hFF last -> 5 matches detected, match_count=3, count_sat=1; next start clears both.
- Handshake: in_valid held high with words 8'hB0, 8'h0B (last) -> in_ready high only in LOAD cycles, each word accepted exactly once, 18 cycles from start to done; pattern 1011 overlap -> match_count=2.
- Reset mid-SHIFT: assert reset_n=0 during the 3rd bit of a word -> all outputs 0 immediately, FSM in IDLE; a later in_valid is not accepted without a new start.
